// File: rtl/twi_uart_formatter_if.sv
// Event-capture and UART-transmitter signals seen by the TWI-to-UART formatter.
// slave  : the formatter's view (consumes events, drives the transmitter request)
// master : the surrounding system's view (event source plus transmitter)
interface twi_uart_formatter_if;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [7:0] evt_data;
    logic       evt_ack;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output evt_valid, evt_type, evt_data, evt_ack, tx_busy,
        input  tx_start, tx_data
    );

    modport slave (
        input  evt_valid, evt_type, evt_data, evt_ack, tx_busy,
        output tx_start, tx_data
    );
endinterface

// File: rtl/twi_uart_formatter.sv
// TWI bus-event formatter: buffers START/STOP/DATA events in a FIFO and turns
// each into a short ASCII sequence, handed one character at a time to a UART
// transmitter through its start/busy handshake. Events arriving while the FIFO
// is full are dropped and latched in a sticky overflow flag.
module twi_uart_formatter #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    twi_uart_formatter_if.slave     bus,
    input  logic                    ovf_clr,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    fmt_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, HOLD, WAIT} state_t;

    // Entry layout: [10:9] type, [8] ack, [7:0] data byte
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [10:0]   fifoHead;
    logic          pushOk;
    logic          dropEvt;
    logic          popEn;

    state_t        state;
    state_t        stateNext;
    logic [10:0]   holdReg;
    logic [10:0]   holdNext;
    logic [1:0]    charIdx;
    logic [1:0]    idxNext;
    logic [7:0]    txData;
    logic [7:0]    txDataNext;

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character number idx of the sequence for one stored event
    function automatic logic [7:0] charFor(input logic [10:0] e, input logic [1:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case (e[10:9])
            2'd0: c = 8'h53;
            2'd1: begin
                case (idx)
                    2'd0:    c = 8'h50;
                    2'd1:    c = 8'h0D;
                    default: c = 8'h0A;
                endcase
            end
            2'd2: begin
                case (idx)
                    2'd0:    c = hexChar(e[7:4]);
                    2'd1:    c = hexChar(e[3:0]);
                    default: c = e[8] ? 8'h41 : 8'h4E;
                endcase
            end
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Index of the final character: START is one character, STOP and DATA three
    function automatic logic [1:0] lastIdx(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : 2'd2;
    endfunction

    // Fullness is judged on the level before any same-cycle pop
    assign pushOk   = bus.evt_valid && (fifo_level != FULL_LVL);
    assign dropEvt  = bus.evt_valid && (fifo_level == FULL_LVL);
    assign fifoHead = mem[rdPtr];

    // FIFO storage; payload only, so it carries no reset
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= {bus.evt_type, bus.evt_ack, bus.evt_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_level <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + AW'(1);
            if (popEn)  rdPtr <= rdPtr + AW'(1);
            case ({pushOk, popEn})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky loss flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (dropEvt) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Emitter state, holding register, character index and outgoing character
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            holdReg <= '0;
            charIdx <= '0;
            txData  <= '0;
        end else begin
            state   <= stateNext;
            holdReg <= holdNext;
            charIdx <= idxNext;
            txData  <= txDataNext;
        end
    end

    // Next-state logic: pop in IDLE, request in EMIT, skip one cycle of busy
    // latency in HOLD, then wait for the transmitter to finish in WAIT
    always_comb begin
        stateNext  = state;
        holdNext   = holdReg;
        idxNext    = charIdx;
        txDataNext = txData;
        popEn      = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    popEn = 1'b1;
                    if (fifoHead[10:9] != 2'd3) begin
                        holdNext   = fifoHead;
                        idxNext    = 2'd0;
                        txDataNext = charFor(fifoHead, 2'd0);
                        stateNext  = EMIT;
                    end
                end
            end
            EMIT: begin
                if (!bus.tx_busy) stateNext = HOLD;
            end
            HOLD: begin
                stateNext = WAIT;
            end
            WAIT: begin
                if (!bus.tx_busy) begin
                    if (charIdx == lastIdx(holdReg[10:9])) begin
                        stateNext = IDLE;
                    end else begin
                        idxNext    = charIdx + 2'd1;
                        txDataNext = charFor(holdReg, charIdx + 2'd1);
                        stateNext  = EMIT;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.tx_start = (state == EMIT) && !bus.tx_busy;
    assign bus.tx_data  = txData;
    assign fmt_busy     = (state != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_twi_uart_formatter.sv
// Directed bench for twi_uart_formatter with a small UART transmitter model
// that raises busy for a programmable number of cycles after each tx_start.
module tb_twi_uart_formatter;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       overflow;
    logic [3:0] fifo_level;
    logic       fmt_busy;

    twi_uart_formatter_if ifc();

    twi_uart_formatter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ifc),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .fmt_busy   (fmt_busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         busyLen = 10;
    logic       forceBusy = 1'b0;
    int         busyCnt = 0;
    int         cyc = 0;
    int         lastStart = -100;
    int         peakLvl = 0;
    logic [7:0] txq[$];
    logic [7:0] expq[$];

    assign ifc.tx_busy = forceBusy || (busyCnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: busy for busyLen cycles after accepting a start
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.tx_start) busyCnt <= busyLen;
        else if (busyCnt != 0) busyCnt <= busyCnt - 1;
    end

    // Character capture and handshake rules
    always @(negedge clk) begin
        if (int'(fifo_level) > peakLvl) peakLvl = int'(fifo_level);
        if (ifc.tx_start === 1'b1) begin
            check("start_while_busy", ifc.tx_busy, 32'd0);
            check("start_spacing", (cyc - lastStart) >= 2, 32'd1);
            lastStart = cyc;
            txq.push_back(ifc.tx_data);
        end
    end

    // Must be called at a negedge; event is taken at the following posedge
    task automatic pushEvt(input logic [1:0] t, input logic [7:0] d, input logic a);
        ifc.evt_valid = 1'b1;
        ifc.evt_type  = t;
        ifc.evt_data  = d;
        ifc.evt_ack   = a;
        @(negedge clk);
        ifc.evt_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCyc);
        int n;
        n = 0;
        while ((fmt_busy || ifc.tx_busy) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < maxCyc, 32'd1);
    endtask

    task automatic releaseBusy();
        @(posedge clk);
        #1 forceBusy = 1'b0;
    endtask

    task automatic checkSeq(input string tag);
        check({tag, "_count"}, txq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), txq[i], expq[i]);
        end
    endtask

    // After the target character is seen, step to the IDLE cycle that pops the
    // next entry (busyLen=1 timing) and push an event onto that same edge
    task automatic alignedPush(input int target, input string tag,
                               input logic [3:0] expLvl, input logic expOvf);
        int n;
        n = 0;
        while (txq.size() < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_reach"}, n < 200, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        forceBusy     = 1'b1;
        ifc.evt_valid = 1'b1;
        ifc.evt_type  = 2'd2;
        ifc.evt_data  = 8'h77;
        ifc.evt_ack   = 1'b1;
        @(negedge clk);
        ifc.evt_valid = 1'b0;
        check({tag, "_level"}, fifo_level, expLvl);
        check({tag, "_ovf"}, overflow, expOvf);
    endtask

    logic [7:0] evData [10] = '{8'h00, 8'h9F, 8'hA1, 8'h3B, 8'hFE,
                                8'h7C, 8'h46, 8'hD2, 8'h11, 8'h22};

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifc.evt_valid = 1'b0;
        ifc.evt_type  = 2'd0;
        ifc.evt_data  = 8'h00;
        ifc.evt_ack   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", ifc.tx_start, 32'd0);
        check("rst_tx_data", ifc.tx_data, 32'h00);
        check("rst_overflow", overflow, 32'd0);
        check("rst_level", fifo_level, 32'd0);
        check("rst_fmt_busy", fmt_busy, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // DATA 0x3C ACK, 10-cycle busy per character; first-request latency
        busyLen = 10;
        txq.delete();
        pushEvt(2'd2, 8'h3C, 1'b1);
        check("lat_level", fifo_level, 32'd1);
        @(negedge clk);
        check("lat_start", ifc.tx_start, 32'd1);
        check("lat_data", ifc.tx_data, 32'h33);
        check("lat_level_pop", fifo_level, 32'd0);
        waitIdle("d3c_idle", 1000);
        expq = '{8'h33, 8'h43, 8'h41};
        checkSeq("d3c");
        check("d3c_fmt_busy", fmt_busy, 32'd0);

        // START, DATA 0xA5 NACK, STOP on consecutive cycles
        busyLen = 2;
        txq.delete();
        peakLvl = 0;
        pushEvt(2'd0, 8'h00, 1'b0);
        pushEvt(2'd2, 8'hA5, 1'b0);
        pushEvt(2'd1, 8'h00, 1'b0);
        waitIdle("seq_idle", 1000);
        expq = '{8'h53, 8'h41, 8'h35, 8'h4E, 8'h50, 8'h0D, 8'h0A};
        checkSeq("seq");
        check("seq_peak", (peakLvl == 2) || (peakLvl == 3), 32'd1);
        check("seq_level", fifo_level, 32'd0);

        // Overflow: transmitter held busy, blocker START then 10 DATA events
        forceBusy = 1'b1;
        txq.delete();
        pushEvt(2'd0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            pushEvt(2'd2, evData[i], (i % 2) == 0);
        end
        check("ovf_level", fifo_level, 32'd8);
        check("ovf_set", overflow, 32'd1);
        ovf_clr = 1'b1;
        pushEvt(2'd2, 8'h33, 1'b1);
        ovf_clr = 1'b0;
        check("ovf_clr_vs_drop", overflow, 32'd1);
        check("ovf_level_kept", fifo_level, 32'd8);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 32'd0);
        releaseBusy();
        waitIdle("ovf_idle", 2000);
        expq = '{8'h53,
                 8'h30, 8'h30, 8'h41,  8'h39, 8'h46, 8'h4E,
                 8'h41, 8'h31, 8'h41,  8'h33, 8'h42, 8'h4E,
                 8'h46, 8'h45, 8'h41,  8'h37, 8'h43, 8'h4E,
                 8'h34, 8'h36, 8'h41,  8'h44, 8'h32, 8'h4E};
        checkSeq("ovf");
        check("ovf_drain_level", fifo_level, 32'd0);

        // Reserved type is discarded silently
        txq.delete();
        pushEvt(2'd3, 8'h99, 1'b1);
        pushEvt(2'd0, 8'h00, 1'b0);
        waitIdle("rsv_idle", 1000);
        expq = '{8'h53};
        checkSeq("rsv");
        check("rsv_level", fifo_level, 32'd0);

        // Push coinciding with pop at DEPTH-1 and at DEPTH
        busyLen = 1;
        forceBusy = 1'b1;
        txq.delete();
        pushEvt(2'd0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) begin
            pushEvt(2'd2, 8'h10 + 8'(i), 1'b1);
        end
        check("pp_pre_level", fifo_level, 32'd7);
        releaseBusy();
        alignedPush(txq.size() + 1, "pp_dm1", 4'd7, 1'b0);
        pushEvt(2'd2, 8'h88, 1'b1);
        check("pp_full_level", fifo_level, 32'd8);
        releaseBusy();
        alignedPush(txq.size() + 3, "pp_full", 4'd7, 1'b1);
        releaseBusy();
        waitIdle("pp_idle", 2000);
        check("pp_drain_level", fifo_level, 32'd0);

        // Asynchronous reset in the middle of DATA 0xFF
        busyLen = 3;
        txq.delete();
        pushEvt(2'd2, 8'hFF, 1'b1);
        pushEvt(2'd0, 8'h00, 1'b0);
        check("rst2_ovf_before", overflow, 32'd1);
        n = 0;
        while (txq.size() < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst2_reach", n < 200, 32'd1);
        check("rst2_level_before", fifo_level, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_tx_start", ifc.tx_start, 32'd0);
        check("rst2_tx_data", ifc.tx_data, 32'h00);
        check("rst2_overflow", overflow, 32'd0);
        check("rst2_level", fifo_level, 32'd0);
        check("rst2_fmt_busy", fmt_busy, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst2_no_more_chars", txq.size(), 32'd2);
        check("rst2_level_after", fifo_level, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twi_uart_formatter.md
Name: twi_uart_formatter

Overview:
- Sits between the TWI bus-event capture stage and the UART transmitter.
- Buffers TWI bus events (START, STOP, DATA byte plus ACK bit) in a small FIFO.
- Converts each event to a fixed ASCII sequence and feeds it to the transmitter one character at a time, using the transmitter's start/busy handshake.
- Drops events when the FIFO is full and flags the loss with a sticky overflow bit.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
evt_valid  input  1  one-cycle event strobe from TWI capture
evt_type  input  2  0=START, 1=STOP, 2=DATA, 3=reserved
evt_data  input  8  byte value; meaningful for DATA only
evt_ack  input  1  1=ACK, 0=NACK; meaningful for DATA only
tx_start  output  1  one-cycle request to the UART transmitter
tx_data  output  8  character to transmit; valid while tx_start=1
tx_busy  input  1  transmitter busy flag
ovf_clr  input  1  clears overflow
overflow  output  1  sticky; set when an event is dropped
fifo_level  output  log2(DEPTH)+1  number of stored events
fmt_busy  output  1  1 while the FSM is not IDLE or fifo_level is not 0

Behaviour:
- Reset (async, rst_n=0): FIFO empty, fifo_level=0, overflow=0, FSM=IDLE, tx_start=0, tx_data=0x00, holding register cleared. Reset mid-character abandons the event with no further tx_start.
- FIFO entry: {evt_type, evt_ack, evt_data}, 11 bits.
- Push: at a clk edge with evt_valid=1.
  - Accepted only if fifo_level<DEPTH, judged before any pop in the same cycle.
  - If full, the event is dropped and overflow is set.
- Same-cycle push and pop when not full: both happen; fifo_level is unchanged. Pointers wrap modulo DEPTH.
- overflow: ovf_clr=1 clears it. If ovf_clr and a drop occur in the same cycle, set wins.
- Character sequences:
  - START -> 'S' (0x53).
  - STOP -> 'P' (0x50), CR (0x0D), LF (0x0A).
  - DATA -> high-nibble hex, low-nibble hex, then 'A' (0x41) if evt_ack=1 else 'N' (0x4E).
  - Type 3 -> popped, nothing emitted, FSM returns to IDLE.
- Hex encoding: nibble n<10 -> 0x30+n; n>=10 -> 0x41+n-10. Uppercase only.
- FSM states and transitions:
  - IDLE: if fifo_level!=0, pop into the holding register, set char index=0, load tx_data with the first character, go to EMIT. A type-3 pop stays in IDLE.
  - EMIT: tx_start=1 only when tx_busy=0; transition to HOLD on that cycle. If tx_busy=1, wait in EMIT with tx_start=0.
  - HOLD: exactly one cycle; tx_busy is ignored to cover the transmitter's one-cycle busy assertion latency. Go to WAIT.
  - WAIT: when tx_busy=0, either go to EMIT with the next character loaded into tx_data and the index incremented, or go to IDLE if the last character of the event was sent.
- tx_start is decoded as (state==EMIT) & ~tx_busy. tx_data is registered and stable throughout EMIT.
- Never two tx_start pulses within fewer than 2 cycles. Never a tx_start while tx_busy=1.
- Latency:
  - Event accepted at edge E0 into an empty FIFO with the FSM idle: popped at E1; tx_start high in the cycle after E1, provided tx_busy=0.
  - Back-to-back events: the next pop occurs in the IDLE cycle after the last character's WAIT exit; there is no dead time beyond that IDLE cycle.
- fifo_level updates on the edge of push/pop. It is visible the cycle after.

Test Plan:
- DATA 0x3C with ack=1, transmitter model holds busy 10 cycles per char -> tx_data sequence 0x33, 0x43, 0x41; exactly 3 tx_start pulses, each while busy=0; fmt_busy falls after the last one.
- START, DATA 0xA5 ack=0, STOP on consecutive cycles -> 0x53, 0x41, 0x35, 0x4E, 0x50, 0x0D, 0x0A in order; fifo_level peaks at 2 or 3 and returns to 0.
- tx_busy forced to 1, 10 DATA events pushed (DEPTH=8) -> fifo_level=8, overflow=1, events 9 and 10 absent. Release busy -> 24 chars for events 1-8. ovf_clr asserted together with a further drop -> overflow stays 1.
- Event types 3, then START -> only 0x53 emitted; fifo_level returns to 0.
- rst_n pulsed low after the second char of DATA 0xFF -> outputs go to reset values immediately (asynchronously); no further tx_start; overflow=0; fifo_level=0.
- Push while popping in the same cycle, FIFO at DEPTH-1 and at DEPTH -> at DEPTH-1 the level is unchanged with no drop; at DEPTH the push is dropped and overflow is set.
